// File: rtl/piso_pkg.sv
// Shared types and sizing helpers for the parallel-in/serial-out transmitter and its receiver.
// Optional even parity bit is enabled by defining PISO_PARITY_EN.
package piso_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

`ifdef PISO_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

    // Bits per frame: data word plus the appended parity bit when enabled.
    function automatic int frame_len(input int width);
        return width + PARITY_BITS;
    endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Parallel word handshake plus serial frame outputs of the serializer.
// The serializer uses the slave view; the word source uses the master view.
interface piso_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             ser_out;
    logic             ser_valid;
    logic             ser_last;
    logic             done;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  ser_out,
        input  ser_valid,
        input  ser_last,
        input  done
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output ser_out,
        output ser_valid,
        output ser_last,
        output done
    );
endinterface

// File: rtl/bit_counter.sv
// Synchronous up-counter with restart, enable and terminal-count flag.
// Latency: count updates on the edge after en; tc is decoded from the held count.
// Backpressure: none; the owner gates en.
module bit_counter #(
    parameter int CNT_W = 4,
    parameter int TERM  = 7
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             restart,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    always_ff @(posedge clk) begin
        if (clr || restart) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tc = (cnt == CNT_W'(TERM));

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: one word per frame, one bit per clk, optional parity (PISO_PARITY_EN).
// Latency: first bit the cycle after accept; frame lasts FRAME_LEN cycles; done one cycle after the last bit.
// Backpressure: in_ready only in IDLE or on the last bit, allowing gap-free back-to-back frames.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic                clk,
    input  logic                clr,
    piso_serializer_if.slave    bus
);

    localparam int FRAME_LEN = frame_len(WIDTH);
    localparam int CNT_W     = clog2(WIDTH + 1);

    state_t             state;
    logic [WIDTH-1:0]   shreg;
    logic [CNT_W-1:0]   cnt;
    logic               cnt_tc;
    logic               done_q;
    logic               last;
    logic               accept;
    logic               data_bit;
    logic               frame_bit;

    assign last         = (state == ST_SHIFT) && cnt_tc;
    assign bus.in_ready = (state == ST_IDLE) || last;
    assign accept       = bus.in_valid && bus.in_ready;
    assign data_bit     = LSB_FIRST ? shreg[0] : shreg[WIDTH-1];

    // Counter freezes on the last bit so it never wraps, even in IDLE.
    bit_counter #(
        .CNT_W (CNT_W),
        .TERM  (FRAME_LEN - 1)
    ) u_bit_counter (
        .clk     (clk),
        .clr     (clr),
        .restart (accept),
        .en      ((state == ST_SHIFT) && !cnt_tc),
        .cnt     (cnt),
        .tc      (cnt_tc)
    );

`ifdef PISO_PARITY_EN
    logic par_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            par_q <= 1'b0;
        end else if (accept) begin
            par_q <= ^bus.in_data;
        end
    end

    assign frame_bit = (cnt == CNT_W'(WIDTH)) ? par_q : data_bit;
`else
    assign frame_bit = data_bit;
`endif

    always_ff @(posedge clk) begin
        if (clr) begin
            state  <= ST_IDLE;
            shreg  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= last;
            if (accept) begin
                state <= ST_SHIFT;
                shreg <= bus.in_data;
            end else if (last) begin
                state <= ST_IDLE;
            end else if (state == ST_SHIFT) begin
                shreg <= LSB_FIRST ? (shreg >> 1) : (shreg << 1);
            end
        end
    end

    assign bus.ser_valid = (state == ST_SHIFT);
    assign bus.ser_out   = (state == ST_SHIFT) && frame_bit;
    assign bus.ser_last  = last;
    assign bus.done      = done_q;

endmodule
